// File: rtl/anf_fl_tex_etc2_fetch_ctrl.sv
// ETC2 texel fetch sequencer: one-entry tagged block buffer, miss fill from memory, registered decode/response.
// Optional hit/miss perf counters enabled by defining TEX_FETCH_PERF_CNT_EN.
module anf_fl_tex_etc2_fetch_ctrl #(
  parameter int unsigned BLK_W = 28,
  parameter int unsigned ID_W  = 4
`ifdef TEX_FETCH_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [BLK_W-1:0] req_blk,
  input  logic [1:0]       req_x,
  input  logic [1:0]       req_y,
  input  logic [4:0]       req_format,
  input  logic [ID_W-1:0]  req_id,
  input  logic             inv,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [BLK_W-1:0] mem_req_blk,
  input  logic             mem_rsp_valid,
  input  logic [127:0]     mem_rsp_data,
  output logic [127:0]     dec_data,
  output logic [4:0]       dec_format,
  output logic [1:0]       dec_x,
  output logic [1:0]       dec_y,
  input  logic [7:0]       dec_r,
  input  logic [7:0]       dec_g,
  input  logic [7:0]       dec_b,
  input  logic [7:0]       dec_a,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rgba,
  output logic [ID_W-1:0]  rsp_id
`ifdef TEX_FETCH_PERF_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_DECODE,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             tag_valid_q, tag_valid_d;
  logic [BLK_W-1:0] tag_q, tag_d;
  logic [127:0]     buf_q, buf_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic             req_ready_q, req_ready_d;
  logic             mem_req_valid_q, mem_req_valid_d;
  logic [BLK_W-1:0] mem_req_blk_q, mem_req_blk_d;
  logic [127:0]     dec_data_q, dec_data_d;
  logic [4:0]       dec_format_q, dec_format_d;
  logic [1:0]       dec_x_q, dec_x_d;
  logic [1:0]       dec_y_q, dec_y_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rgba_q, rsp_rgba_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

  logic             accept;
  logic             hit;

  assign accept = (state_q == S_IDLE) && req_valid;
  // Uses the registered tag_valid, so an inv in the accept cycle does not affect this lookup.
  assign hit    = tag_valid_q && (tag_q == req_blk);

`ifdef TEX_FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (accept) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  always_comb begin
    state_d         = state_q;
    tag_valid_d     = tag_valid_q;
    tag_d           = tag_q;
    buf_d           = buf_q;
    id_d            = id_q;
    req_ready_d     = req_ready_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_blk_d   = mem_req_blk_q;
    dec_data_d      = dec_data_q;
    dec_format_d    = dec_format_q;
    dec_x_d         = dec_x_q;
    dec_y_d         = dec_y_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_rgba_d      = rsp_rgba_q;
    rsp_id_d        = rsp_id_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // mem_req_blk doubles as the latched block index for the whole transaction.
          mem_req_blk_d = req_blk;
          dec_x_d       = req_x;
          dec_y_d       = req_y;
          dec_format_d  = req_format;
          id_d          = req_id;
          req_ready_d   = 1'b0;
          if (hit) begin
            dec_data_d = buf_q;
            state_d    = S_DECODE;
          end else begin
            mem_req_valid_d = 1'b1;
            state_d         = S_MISS_REQ;
          end
        end
      end
      S_MISS_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = S_MISS_WAIT;
        end
      end
      S_MISS_WAIT: begin
        if (mem_rsp_valid) begin
          buf_d       = mem_rsp_data;
          dec_data_d  = mem_rsp_data;
          tag_d       = mem_req_blk_q;
          tag_valid_d = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        rsp_rgba_d  = {dec_r, dec_g, dec_b, dec_a};
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d         = S_IDLE;
        req_ready_d     = 1'b1;
        mem_req_valid_d = 1'b0;
        rsp_valid_d     = 1'b0;
      end
    endcase

    // Invalidate overrides a coincident fill; the filled data still serves the pending request.
    if (inv) tag_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      tag_valid_q     <= 1'b0;
      tag_q           <= '0;
      buf_q           <= '0;
      id_q            <= '0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_blk_q   <= '0;
      dec_data_q      <= '0;
      dec_format_q    <= '0;
      dec_x_q         <= '0;
      dec_y_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_rgba_q      <= '0;
      rsp_id_q        <= '0;
    end else begin
      state_q         <= state_d;
      tag_valid_q     <= tag_valid_d;
      tag_q           <= tag_d;
      buf_q           <= buf_d;
      id_q            <= id_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_blk_q   <= mem_req_blk_d;
      dec_data_q      <= dec_data_d;
      dec_format_q    <= dec_format_d;
      dec_x_q         <= dec_x_d;
      dec_y_q         <= dec_y_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rgba_q      <= rsp_rgba_d;
      rsp_id_q        <= rsp_id_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_blk   = mem_req_blk_q;
  assign dec_data      = dec_data_q;
  assign dec_format    = dec_format_q;
  assign dec_x         = dec_x_q;
  assign dec_y         = dec_y_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rgba      = rsp_rgba_q;
  assign rsp_id        = rsp_id_q;

endmodule

// File: tb/tb_anf_fl_tex_etc2_fetch_ctrl.sv
// Randomized + directed bench for anf_fl_tex_etc2_fetch_ctrl against a transaction-level buffer model.
// Perf counter checks compile in when TEX_FETCH_PERF_CNT_EN is defined.
module tb_anf_fl_tex_etc2_fetch_ctrl;
  localparam int unsigned BLK_W = 28;
  localparam int unsigned ID_W  = 4;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0, req_ready;
  logic [BLK_W-1:0] req_blk = '0;
  logic [1:0]       req_x = '0, req_y = '0;
  logic [4:0]       req_format = '0;
  logic [ID_W-1:0]  req_id = '0;
  logic             inv = 1'b0;
  logic             mem_req_valid, mem_req_ready = 1'b0;
  logic [BLK_W-1:0] mem_req_blk;
  logic             mem_rsp_valid = 1'b0;
  logic [127:0]     mem_rsp_data = '0;
  logic [127:0]     dec_data;
  logic [4:0]       dec_format;
  logic [1:0]       dec_x, dec_y;
  logic [7:0]       dec_r, dec_g, dec_b, dec_a;
  logic             rsp_valid, rsp_ready = 1'b0;
  logic [31:0]      rsp_rgba;
  logic [ID_W-1:0]  rsp_id;
  logic             cnt_clr = 1'b0;
`ifdef TEX_FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  logic [CNT_W-1:0] m_hit = '0, m_miss = '0;
`endif

  always #5 clk = ~clk;

  // Stub decoder: byte at texel index, a derived channel, the next byte, and the format code.
  function automatic logic [31:0] dec_fn(input logic [127:0] d, input logic [1:0] x, input logic [1:0] y,
                                         input logic [4:0] f);
    int idx;
    logic [7:0] b0, b1;
    idx = 4 * int'(y) + int'(x);
    b0  = d[idx*8 +: 8];
    b1  = d[((idx + 1) % 16)*8 +: 8];
    return {b0, b0 ^ 8'h5a, b1, {3'b000, f}};
  endfunction

  assign {dec_r, dec_g, dec_b, dec_a} = dec_fn(dec_data, dec_x, dec_y, dec_format);

  anf_fl_tex_etc2_fetch_ctrl #(.BLK_W(BLK_W), .ID_W(ID_W)
`ifdef TEX_FETCH_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_blk(req_blk), .req_x(req_x), .req_y(req_y),
    .req_format(req_format), .req_id(req_id), .inv(inv),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_blk(mem_req_blk),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .dec_data(dec_data), .dec_format(dec_format), .dec_x(dec_x), .dec_y(dec_y),
    .dec_r(dec_r), .dec_g(dec_g), .dec_b(dec_b), .dec_a(dec_a),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rgba(rsp_rgba), .rsp_id(rsp_id)
`ifdef TEX_FETCH_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int unsigned n_pass = 0, n_chk = 0;

  // Buffer model: what the one-entry buffer holds after each transaction.
  bit               m_tv = 1'b0;
  logic [BLK_W-1:0] m_tag = '0;
  logic [127:0]     m_buf = '0;
  bit               exp_active = 1'b0;
  logic [31:0]      exp_rgba = '0;
  logic [ID_W-1:0]  exp_id = '0;
  logic [BLK_W-1:0] exp_mem_blk = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Continuous response/memory-request checker.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        chk("rsp_expected", rsp_valid & exp_active, 1'b1);
        chk("rsp_rgba", rsp_rgba, exp_rgba);
        chk("rsp_id", rsp_id, exp_id);
      end
      if (mem_req_valid) chk("mem_req_blk", mem_req_blk, exp_mem_blk);
    end
  end

  task automatic txn(input logic [BLK_W-1:0] blk, input logic [1:0] x, input logic [1:0] y,
                     input logic [4:0] f, input logic [ID_W-1:0] id,
                     input int unsigned mdly, input int unsigned gap, input int unsigned rdly,
                     input bit inv_acc, input bit inv_fill, input bit clr_acc, input logic [127:0] fdata);
    bit hit;
    int unsigned n;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", req_ready, 1'b1);
    hit = m_tv && (m_tag == blk);
    req_valid = 1'b1; req_blk = blk; req_x = x; req_y = y; req_format = f; req_id = id;
    inv = inv_acc; cnt_clr = clr_acc;
    exp_id = id; exp_mem_blk = blk;
    exp_rgba = dec_fn(hit ? m_buf : fdata, x, y, f);
    exp_active = 1'b1;
`ifdef TEX_FETCH_PERF_CNT_EN
    if (clr_acc) begin m_hit = '0; m_miss = '0; end
    else if (hit) begin if (m_hit != '1) m_hit++; end
    else begin if (m_miss != '1) m_miss++; end
`endif
    if (inv_acc) m_tv = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; inv = 1'b0; cnt_clr = 1'b0;
    chk("req_ready_busy", req_ready, 1'b0);
    chk("dec_xy_fmt", {dec_x, dec_y, dec_format}, {x, y, f});
    if (hit) begin
      chk("hit_no_memreq", mem_req_valid, 1'b0);
      chk("hit_rsp_not_early", rsp_valid, 1'b0);
      chk("hit_dec_data", dec_data, m_buf);
      @(negedge clk);
    end else begin
      chk("miss_memreq", mem_req_valid, 1'b1);
      for (int unsigned i = 0; i < mdly; i++) begin
        @(negedge clk);
        chk("memreq_held", mem_req_valid, 1'b1);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("memreq_drop", mem_req_valid, 1'b0);
      for (int unsigned i = 0; i < gap; i++) begin
        @(negedge clk);
        chk("wait_no_rsp", rsp_valid, 1'b0);
      end
      mem_rsp_valid = 1'b1; mem_rsp_data = fdata; inv = inv_fill;
      @(negedge clk);
      mem_rsp_valid = 1'b0; inv = 1'b0;
      mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
      m_buf = fdata; m_tag = blk; m_tv = !inv_fill;
      chk("fill_rsp_not_early", rsp_valid, 1'b0);
      chk("fill_dec_data", dec_data, fdata);
      @(negedge clk);
    end
    chk("rsp_latency", rsp_valid, 1'b1);
    for (int unsigned i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("rsp_held", rsp_valid, 1'b1);
      chk("req_ready_blocked", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
    exp_active = 1'b0;
`ifdef TEX_FETCH_PERF_CNT_EN
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
`endif
  endtask

  localparam logic [127:0] RAMP = 128'h0f0e0d0c0b0a09080706050403020100;

  initial begin
    logic [127:0] d;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_req", {mem_req_valid, mem_req_blk}, '0);
    chk("rst_rsp", {rsp_valid, rsp_rgba, rsp_id}, '0);
    chk("rst_dec", {dec_data, dec_format, dec_x, dec_y}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss then hit on the same block, with literal decoded values.
    txn(28'h10, 2'd1, 2'd2, 5'd5, 4'd3, 0, 1, 0, 1'b0, 1'b0, 1'b0, RAMP);
    chk("lit_cold_rgba", rsp_rgba, 32'h09530a05);
    chk("lit_cold_id", rsp_id, 4'd3);
    txn(28'h10, 2'd3, 2'd0, 5'd5, 4'd7, 0, 0, 0, 1'b0, 1'b0, 1'b0, '0);
    chk("lit_hit_rgba", rsp_rgba, 32'h03590405);

    // Tag replacement, then memory and consumer back-pressure.
    txn(28'h11, 2'd0, 2'd0, 5'd1, 4'd1, 0, 0, 0, 1'b0, 1'b0, 1'b0, ~RAMP);
    txn(28'h10, 2'd2, 2'd1, 5'd2, 4'd2, 5, 2, 4, 1'b0, 1'b0, 1'b0, RAMP ^ 128'h55);

    // Invalidate with the fill, and invalidate with a hitting accept.
    txn(28'h12, 2'd1, 2'd1, 5'd3, 4'd9, 1, 0, 0, 1'b0, 1'b1, 1'b0, {4{32'hdeadbeef}});
    txn(28'h12, 2'd1, 2'd3, 5'd3, 4'd10, 0, 0, 0, 1'b0, 1'b0, 1'b0, {4{32'h13579bdf}});
    txn(28'h12, 2'd0, 2'd3, 5'd4, 4'd11, 0, 0, 0, 1'b1, 1'b0, 1'b0, '0);
    txn(28'h12, 2'd2, 2'd2, 5'd4, 4'd12, 0, 0, 0, 1'b0, 1'b0, 1'b0, {4{32'h2468ace0}});

`ifdef TEX_FETCH_PERF_CNT_EN
    // Clear with a coincident hit, then 2 misses + 3 hits.
    txn(28'h12, 2'd0, 2'd0, 5'd0, 4'd0, 0, 0, 0, 1'b0, 1'b0, 1'b1, '0);
    chk("lit_clr_hit", hit_cnt, '0);
    chk("lit_clr_miss", miss_cnt, '0);
    txn(28'h30, 2'd0, 2'd0, 5'd0, 4'd1, 0, 0, 0, 1'b0, 1'b0, 1'b0, RAMP);
    txn(28'h30, 2'd1, 2'd0, 5'd0, 4'd2, 0, 0, 0, 1'b0, 1'b0, 1'b0, '0);
    txn(28'h31, 2'd2, 2'd0, 5'd0, 4'd3, 0, 0, 0, 1'b0, 1'b0, 1'b0, ~RAMP);
    txn(28'h31, 2'd3, 2'd0, 5'd0, 4'd4, 0, 0, 0, 1'b0, 1'b0, 1'b0, '0);
    txn(28'h31, 2'd0, 2'd1, 5'd0, 4'd5, 0, 0, 0, 1'b0, 1'b0, 1'b0, '0);
    chk("lit_hit3", hit_cnt, 32'd3);
    chk("lit_miss2", miss_cnt, 32'd2);
`endif

    // Randomized traffic over a few blocks, with stray fills and lone invalidates in idle.
    for (int k = 0; k < 150; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      txn(BLK_W'(28'h40 + $urandom_range(0, 3)), 2'($urandom), 2'($urandom), 5'($urandom), 4'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 14) == 0), d);
      if ($urandom_range(0, 4) == 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("stray_fill_ignored", {rsp_valid, req_ready}, 2'b01);
      end
      if ($urandom_range(0, 9) == 0) begin
        inv = 1'b1; m_tv = 1'b0;
        @(negedge clk);
        inv = 1'b0;
      end
    end

    // Async reset in the middle of a miss; the late fill must be ignored.
    req_valid = 1'b1; req_blk = 28'h20; req_x = '0; req_y = '0; req_format = '0; req_id = 4'd6;
    exp_mem_blk = 28'h20;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rst_async_ready", req_ready, 1'b1);
    chk("rst_async_rsp", {rsp_valid, mem_req_valid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    m_tv = 1'b0; exp_active = 1'b0;
`ifdef TEX_FETCH_PERF_CNT_EN
    m_hit = '0; m_miss = '0;
`endif
    mem_rsp_valid = 1'b1; mem_rsp_data = {4{32'hbadbad00}};
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("late_fill_ignored", {rsp_valid, req_ready, mem_req_valid}, 3'b010);
    @(negedge clk);
    chk("late_fill_still_idle", {rsp_valid, req_ready}, 2'b01);
    txn(28'h10, 2'd1, 2'd2, 5'd5, 4'd3, 0, 0, 0, 1'b0, 1'b0, 1'b0, RAMP);
    chk("lit_post_reset_rgba", rsp_rgba, 32'h09530a05);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
